// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and default geometry for the memory arbiter
package mem_pkg;

    localparam int WORDS_DEF   = 8;
    localparam int MEM_LAT_DEF = 4;
    localparam int OFFSET_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFILL  = 2'd1,
        DFILL  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - issue/receive beat counting for one cache block fill
module fill_counter
    import mem_pkg::*;
#(
    parameter int WORDS   = WORDS_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         mem_beat,
    output logic [$clog2(WORDS+1)-1:0]   issue_cnt,
    output logic [$clog2(WORDS+1)-1:0]   recv_cnt,
    output logic                         issuing,
    output logic                         beat,
    output logic                         full
);

    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int AGE_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORDS);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MEM_LAT);

    // Cycles since the fill started, saturating at the memory latency. A beat
    // can only belong to this fill once the first read has had time to return,
    // so earlier beats (leftovers of a fill abandoned by reset) are discarded.
    logic [AGE_W-1:0] age;

    assign issuing = run && (issue_cnt < CNT_MAX);
    assign beat    = run && mem_beat && (recv_cnt < CNT_MAX) && (age == AGE_MAX);
    assign full    = run && (recv_cnt == CNT_MAX);

    // Counters advance only inside a fill and clear on the completing cycle.
    always_ff @(posedge clk) begin
        if (rst || !run || full) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            age       <= '0;
        end else begin
            if (issuing) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (beat) begin
                recv_cnt <= recv_cnt + CNT_W'(1);
            end
            if (age != AGE_MAX) begin
                age <= age + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter for main memory; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WORDS   = WORDS_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic [15:0] i_data,
    output logic        i_data_valid,
    output logic [2:0]  i_word,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic [15:0] d_data,
    output logic        d_data_valid,
    output logic [2:0]  d_word,
    output logic        d_done,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid
);

    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [15:0] BLOCK_MASK = ~((16'd1 << OFFSET_W) - 16'd1);

    arb_state_t       state, state_nxt;
    logic [15:0]      base_addr;
    logic [15:0]      req_addr;
    logic             d_wins;
    logic             any_req;
    logic             in_fill;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic             issuing;
    logic             beat;
    logic             full;

`ifdef MEM_ARB_RR_EN
    // High when I was the last requester served, so D is favoured next.
    logic last_i;
`endif

    assign any_req  = i_req || d_req;
    assign req_addr = d_wins ? d_addr : i_addr;
    assign in_fill  = (state == IFILL) || (state == DFILL);

    // Pick the winner among pending requests.
    always_comb begin
        d_wins = 1'b0;
`ifdef MEM_ARB_RR_EN
        d_wins = d_req && (!i_req || last_i);
`else
        d_wins = d_req;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the block-aligned base of the winning request when leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_addr <= '0;
        end else if (state == IDLE && any_req) begin
            base_addr <= req_addr & BLOCK_MASK;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who was granted last; reset favours D.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_i <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_i <= !d_wins;
        end
    end
`endif

    fill_counter #(
        .WORDS   (WORDS),
        .MEM_LAT (MEM_LAT)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .run       (in_fill),
        .mem_beat  (mem_data_valid),
        .issue_cnt (issue_cnt),
        .recv_cnt  (recv_cnt),
        .issuing   (issuing),
        .beat      (beat),
        .full      (full)
    );

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_wins) begin
                    state_nxt = d_we ? DWRITE : DFILL;
                end else if (i_req) begin
                    state_nxt = IFILL;
                end
            end
            IFILL, DFILL: begin
                if (full) begin
                    state_nxt = IDLE;
                end
            end
            DWRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory command and requester response decode.
    always_comb begin
        i_grant      = (state == IFILL);
        d_grant      = (state == DFILL) || (state == DWRITE);
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_word       = '0;
        i_done       = 1'b0;
        d_data       = '0;
        d_data_valid = 1'b0;
        d_word       = '0;
        d_done       = 1'b0;
        if (state == DWRITE) begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            d_done     = 1'b1;
        end else if (issuing) begin
            mem_enable = 1'b1;
            mem_addr   = base_addr + 16'({issue_cnt, 1'b0});
        end
        if (state == IFILL) begin
            i_data_valid = beat;
            i_data       = beat ? mem_data_out : 16'd0;
            i_word       = beat ? 3'(recv_cnt) : 3'd0;
            i_done       = full;
        end
        if (state == DFILL) begin
            d_data_valid = beat;
            d_data       = beat ? mem_data_out : 16'd0;
            d_word       = beat ? 3'(recv_cnt) : 3'd0;
            d_done       = full;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (MEM_ARB_RR_EN selects round-robin checks)
module tb_mem_arbiter;

    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_grant, i_data_valid, i_done;
    logic [15:0] i_data;
    logic [2:0]  i_word;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [15:0] d_addr = '0, d_wdata = '0;
    logic        d_grant, d_data_valid, d_done;
    logic [15:0] d_data;
    logic [2:0]  d_word;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        model_valid = 1'b0, inject = 1'b0;
    logic [15:0] model_data = '0, inj_data = '0;
    wire  [15:0] mem_data_out   = inject ? inj_data : model_data;
    wire         mem_data_valid = model_valid | inject;

    typedef struct {int t; logic [15:0] addr;} rd_t;
    typedef struct {bit who; int word; logic [15:0] data; int cyc;} beat_t;
    typedef struct {int cyc; bit wr; logic [15:0] addr; logic [15:0] wdata;} mop_t;
    typedef struct {bit who; int cyc;} ev_t;

    rd_t   rd_q[$];
    beat_t beat_q[$], exp_q[$];
    mop_t  mop_q[$];
    ev_t   done_q[$], grant_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit prev_ig = 1'b0, prev_dg = 1'b0;

    mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data(i_data),
        .i_data_valid(i_data_valid), .i_word(i_word), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data(d_data), .d_data_valid(d_data_valid),
        .d_word(d_word), .d_done(d_done),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Pipelined memory: a read seen in cycle t returns in cycle t+MEM_LAT.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        model_valid = 1'b0;
        if (rd_q.size() > 0 && rd_q[0].t + MEM_LAT == cyc) begin
            model_valid = 1'b1;
            model_data  = mem_word(rd_q[0].addr);
            void'(rd_q.pop_front());
        end
    end

    // Observe DUT activity mid-cycle and log it for the tests.
    always @(negedge clk) begin
        if (mem_enable && !mem_wr) rd_q.push_back('{cyc, mem_addr});
        if (mem_enable) mop_q.push_back('{cyc, mem_wr, mem_addr, mem_wdata});
        if (i_data_valid) beat_q.push_back('{1'b0, int'(i_word), i_data, cyc});
        if (d_data_valid) beat_q.push_back('{1'b1, int'(d_word), d_data, cyc});
        if (i_done) done_q.push_back('{1'b0, cyc});
        if (d_done) done_q.push_back('{1'b1, cyc});
        if (i_grant && !prev_ig) grant_q.push_back('{1'b0, cyc});
        if (d_grant && !prev_dg) grant_q.push_back('{1'b1, cyc});
        prev_ig = i_grant;
        prev_dg = d_grant;
    end

    task automatic clear_logs();
        beat_q.delete(); exp_q.delete(); mop_q.delete(); done_q.delete(); grant_q.delete();
    endtask

    task automatic wait_done(input bit who, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (who ? d_done : i_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_fill(input bit who, input logic [15:0] base);
        for (int k = 0; k < WORDS; k++)
            exp_q.push_back('{who, k, mem_word(base + 16'(2 * k)), 0});
    endtask

    task automatic test_reset();
        logic [77:0] outs;
        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h1230; d_addr = 16'h4000;
        repeat (2) @(negedge clk);
        outs = {i_grant, i_data, i_data_valid, i_word, i_done, d_grant, d_data, d_data_valid,
                d_word, d_done, mem_enable, mem_wr, mem_addr, mem_wdata};
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
        n_cmp++;
        if ({dut.u_fill.issue_cnt, dut.u_fill.recv_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_counters got=%h want=0", {dut.u_fill.issue_cnt, dut.u_fill.recv_cnt});
        end
        i_req = 1'b0; d_req = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ifill();
        bit ok;
        int n;
        clear_logs();
        push_fill(1'b0, 16'h1230);
        i_addr = 16'h1236; i_req = 1'b1;
        wait_done(1'b0, 40, ok);
        i_req = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ifill_done_timeout got=0 want=1"); end
        n_cmp++;
        if (mop_q.size() != WORDS) begin n_bad++; $display("FAIL ifill_read_count got=%0d want=%0d", mop_q.size(), WORDS); end
        n = (mop_q.size() < WORDS) ? mop_q.size() : WORDS;
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (mop_q[k].wr !== 1'b0 || mop_q[k].addr !== 16'h1230 + 16'(2 * k) || mop_q[k].cyc != mop_q[0].cyc + k) begin
                n_bad++;
                $display("FAIL ifill_read%0d got wr=%b addr=%h cyc=%0d want wr=0 addr=%h cyc=%0d", k, mop_q[k].wr,
                         mop_q[k].addr, mop_q[k].cyc, 16'h1230 + 16'(2 * k), mop_q[0].cyc + k);
            end
        end
        n_cmp++;
        if (beat_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ifill_beat_count got=%0d want=%0d", beat_q.size(), exp_q.size()); end
        while (beat_q.size() > 0 && exp_q.size() > 0) begin
            beat_t b, e;
            b = beat_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (b.who !== e.who || b.word != e.word || b.data !== e.data) begin
                n_bad++;
                $display("FAIL ifill_beat got who=%0d word=%0d data=%h want who=%0d word=%0d data=%h",
                         b.who, b.word, b.data, e.who, e.word, e.data);
            end
        end
        n_cmp++;
        if (done_q.size() != 1 || mop_q.size() == 0 || done_q[0].cyc - mop_q[0].cyc != 12) begin
            n_bad++;
            $display("FAIL ifill_done_latency got dones=%0d delta=%0d want dones=1 delta=12", done_q.size(),
                     (done_q.size() > 0 && mop_q.size() > 0) ? done_q[0].cyc - mop_q[0].cyc : -1);
        end
    endtask

    task automatic test_priority();
        bit ok_d, ok_i;
        clear_logs();
        push_fill(1'b1, 16'h4000);
        push_fill(1'b0, 16'h2000);
        i_addr = 16'h2000; d_addr = 16'h4000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(1'b1, 40, ok_d);
        d_req = 1'b0;
        wait_done(1'b0, 40, ok_i);
        i_req = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (!ok_d || !ok_i) begin n_bad++; $display("FAIL prio_done_timeout got d=%0d i=%0d want 1 1", ok_d, ok_i); end
        n_cmp++;
        if (grant_q.size() != 2 || grant_q[0].who !== 1'b1 || grant_q[1].who !== 1'b0) begin
            n_bad++; $display("FAIL prio_grant_order got count=%0d want D then I", grant_q.size());
        end else begin
            n_cmp++;
            if (done_q.size() < 1 || grant_q[1].cyc != done_q[0].cyc + 2) begin
                n_bad++; $display("FAIL prio_i_grant_gap got=%0d want=%0d", grant_q[1].cyc,
                                  done_q.size() > 0 ? done_q[0].cyc + 2 : -1);
            end
        end
        n_cmp++;
        if (beat_q.size() != exp_q.size()) begin n_bad++; $display("FAIL prio_beat_count got=%0d want=%0d", beat_q.size(), exp_q.size()); end
        while (beat_q.size() > 0 && exp_q.size() > 0) begin
            beat_t b, e;
            b = beat_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (b.who !== e.who || b.word != e.word || b.data !== e.data) begin
                n_bad++;
                $display("FAIL prio_beat got who=%0d word=%0d data=%h want who=%0d word=%0d data=%h",
                         b.who, b.word, b.data, e.who, e.word, e.data);
            end
        end
    endtask

    task automatic test_dwrite();
        bit ok;
        logic [33:0] cmd;
        int done_cyc;
        clear_logs();
        d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF; d_req = 1'b1;
        wait_done(1'b1, 10, ok);
        cmd = {mem_enable, mem_wr, mem_addr, mem_wdata};
        done_cyc = cyc;
        d_req = 1'b0; d_we = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL dwrite_done_timeout got=0 want=1"); end
        n_cmp++;
        if (cmd !== {1'b1, 1'b1, 16'h0010, 16'hBEEF}) begin
            n_bad++; $display("FAIL dwrite_cmd got=%h want=%h", cmd, {1'b1, 1'b1, 16'h0010, 16'hBEEF});
        end
        n_cmp++;
        if (mop_q.size() != 1 || mop_q[0].cyc != done_cyc) begin
            n_bad++; $display("FAIL dwrite_single_cycle got ops=%0d want ops=1 in done cycle", mop_q.size());
        end
        n_cmp++;
        if (beat_q.size() != 0) begin n_bad++; $display("FAIL dwrite_no_beats got=%0d want=0", beat_q.size()); end
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        clear_logs();
        i_addr = 16'h5556; i_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_enable;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rstfill_start_timeout got=0 want=1"); end
        repeat (2) @(negedge clk);
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({i_grant, mem_enable, i_data_valid, i_done} !== 4'b0) begin
            n_bad++; $display("FAIL rstfill_idle got=%b want=0000", {i_grant, mem_enable, i_data_valid, i_done});
        end
        rst = 1'b0;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (mop_q.size() != 3) begin n_bad++; $display("FAIL rstfill_reads_in_flight got=%0d want=3", mop_q.size()); end
        n_cmp++;
        if (beat_q.size() != 0 || done_q.size() != 0) begin
            n_bad++; $display("FAIL rstfill_late_beats got beats=%0d dones=%0d want 0 0", beat_q.size(), done_q.size());
        end
    endtask

    task automatic test_idle_valid();
        clear_logs();
        inj_data = 16'h1111; inject = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({i_data_valid, d_data_valid, i_done, d_done} !== 4'b0 ||
                {dut.u_fill.issue_cnt, dut.u_fill.recv_cnt} !== '0) begin
                n_bad++;
                $display("FAIL idle_valid got valid=%b cnt=%h want 0 0", {i_data_valid, d_data_valid, i_done, d_done},
                         {dut.u_fill.issue_cnt, dut.u_fill.recv_cnt});
            end
        end
        inject = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit exp_who [4];
`ifdef MEM_ARB_RR_EN
        exp_who = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_who = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        clear_logs();
        d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234; i_addr = 16'h3000;
        d_req = 1'b1; i_req = 1'b1;
        for (int c = 0; c < 120 && grant_q.size() < 4; c++) @(negedge clk);
        d_req = 1'b0; i_req = 1'b0;
        repeat (30) @(negedge clk);
        d_we = 1'b0;
        n_cmp++;
        if (grant_q.size() < 4) begin n_bad++; $display("FAIL b2b_grant_count got=%0d want>=4", grant_q.size()); end
        for (int k = 0; k < 4 && k < grant_q.size(); k++) begin
            n_cmp++;
            if (grant_q[k].who !== exp_who[k]) begin
                n_bad++; $display("FAIL b2b_grant%0d got=%0d want=%0d (1=D)", k, grant_q[k].who, exp_who[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ifill();
        test_priority();
        test_dwrite();
        test_reset_mid_fill();
        test_idle_valid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 8: 16-bit words per cache block fill.
REQ-002 SHALL have parameter MEM_LAT, default 4: main-memory read latency in cycles, pipelined with one new request per cycle.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req in 1 (I-cache fill request) and i_addr in 16 (miss address).
REQ-006 SHALL have ports i_grant out 1, i_data out 16, i_data_valid out 1, i_word out 3 (word index) and i_done out 1.
REQ-007 SHALL have ports d_req in 1, d_we in 1 (1=write-through store, 0=fill), d_addr in 16 and d_wdata in 16.
REQ-008 SHALL have ports d_grant out 1, d_data out 16, d_data_valid out 1, d_word out 3 and d_done out 1.
REQ-009 SHALL have ports mem_enable out 1, mem_wr out 1, mem_addr out 16 and mem_wdata out 16.
REQ-010 SHALL have ports mem_data_out in 16 and mem_data_valid in 1.

Function
REQ-011 SHALL implement FSM states IDLE, IFILL, DFILL and DWRITE.
REQ-012 SHALL, in IDLE with any request pending, register the winner and leave IDLE at the next edge; the grant is asserted throughout the granted state.
REQ-013 SHALL apply fixed priority with D over I when both requests are pending (default build).
REQ-014 SHALL, in a fill state, issue WORDS reads on consecutive cycles: mem_enable=1, mem_wr=0, mem_addr={addr[15:4],4'b0}+2*k for k=0..WORDS-1.
REQ-015 SHALL route each mem_data_valid beat to the granted requester's data bus with *_data_valid=1 and *_word equal to the receive count, incrementing that count.
REQ-016 SHALL pulse *_done for one cycle when the receive count reaches WORDS, then return to IDLE at the next edge.
REQ-017 SHALL, in DWRITE, drive mem_enable=1, mem_wr=1, mem_addr=d_addr and mem_wdata=d_wdata for exactly one cycle, pulse d_done in that same cycle, then return to IDLE.
REQ-018 SHALL make the minimum fill occupancy WORDS+MEM_LAT cycles, and the minimum gap between back-to-back transactions one IDLE cycle.
REQ-019 SHALL require requesters to hold *_req, *_addr and d_wdata stable until *_done; a request dropped mid-transaction does not abort it.
REQ-020 SHALL ignore mem_data_valid in IDLE and DWRITE.
REQ-021 SHALL drive mem_enable=0 in IDLE and after the last issued fill read.
REQ-022 SHALL hold the issue and receive counters at 0 outside the fill states.

Reset
REQ-023 SHALL force, on rst high at a posedge, state=IDLE, both counters=0, the round-robin pointer to favour D, and all outputs to 0.
REQ-024 SHALL, if rst occurs mid-fill, abandon the fill with no *_done pulse, and drop any memory beats still in flight per REQ-020.

Configuration
REQ-025 SHALL, with MEM_ARB_RR_EN defined, replace the REQ-013 fixed priority with round-robin: on a simultaneous request, the requester not served last wins, and the pointer updates on each grant.
REQ-026 SHALL, without MEM_ARB_RR_EN, use the fixed D-over-I priority with no pointer state present.

Structure
REQ-027 SHALL take the FSM state enum, the WORDS and MEM_LAT defaults, and the block-offset width constant from shared package mem_pkg.
REQ-028 SHALL place the issue and receive counting in one sub-module, fill_counter, instantiated once.

Verification
REQ-029 SHALL verify: i_req alone at addr 0x1236 -> reads to 0x1230..0x123E, 8 i_data_valid beats with i_word 0..7, i_done 12 cycles after the first mem_enable.
REQ-030 SHALL verify: i_req and d_req (fill, 0x4000) raised in the same cycle -> d_grant first, then i_grant after d_done plus one IDLE cycle.
REQ-031 SHALL verify: d_req, d_we=1, addr 0x0010, data 0xBEEF -> one cycle with mem_wr=1, mem_addr=0x0010, mem_wdata=0xBEEF, and d_done in that cycle.
REQ-032 SHALL verify: rst asserted 3 cycles into an I fill -> IDLE next cycle, no i_done, and late mem_data_valid beats produce no *_data_valid.
REQ-033 SHALL verify: with MEM_ARB_RR_EN, both requesting continuously -> grants alternate D, I, D, I.
REQ-034 SHALL verify: mem_data_valid pulsed in IDLE -> no *_data_valid and counters stay 0.
